wb_host_ctrl: RTL and testbench
===============================

Name: wb_host_ctrl

Overview:
Parametrised Wishbone host that runs single register transactions for one command/response channel. It is the next generation of the camera-I2C Wishbone controller. It adds:
- valid/ready command intake with per-command address, byte select and data width;
- err/rty termination handling, bounded retries and bus timeout;
- a status-coded response.

It sits between sequencing FSMs (I2C/camera config) and any Wishbone slave core.

Parameters:
DW, 32, data width; must be a multiple of 8.
AW, 32, address width.
PRE_OP_DELAY, 1, idle cycles between command accept and cyc/stb assertion (0 allowed).
TIMEOUT, 1024, max cycles cyc may stay high without termination; 0 disables timeout.
MAX_RETRY, 3, retries allowed after rty (0 means the first rty is final).
RETRY_GAP, 4, cycles cyc is held low between a rty and the reissue (min 1).

Ports:
clk  input  1  clock
rst  input  1  reset
cmd_valid  input  1  command present
cmd_ready  output  1  host can accept a command
cmd_we  input  1  1=write, 0=read
cmd_adr  input  AW  target address
cmd_wdata  input  DW  write data
cmd_sel  input  DW/8  byte selects
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DW  read data (holds until next read completes)
rsp_status  output  2  00 ok, 01 err, 10 rty exhausted, 11 timeout
rsp_retries  output  8  retries used by the completed command
busy  output  1  high whenever state != IDLE
adr_o  output  AW  Wishbone address
dat_o  output  DW  Wishbone write data
dat_i  input  DW  Wishbone read data
cyc_o  output  1  valid bus cycle
stb_o  output  1  strobe
we_o  output  1  write enable
sel_o  output  DW/8  byte select
ack_i  input  1  acknowledge
err_i  input  1  error termination
rty_i  input  1  retry termination

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs are registered.
- Reset values: cmd_ready=0 while rst is high, 1 on the first cycle after release. All other outputs reset to 0 (cyc_o/stb_o drop asynchronously, including mid-transaction). Retry and timer counters clear.
- States: IDLE, DELAY, BUS, GAP.
- IDLE:
  - cmd_ready=1.
  - Accept on the edge where cmd_valid&cmd_ready; latch we/adr/wdata/sel and clear the retry count.
  - Next state is DELAY if PRE_OP_DELAY>0, otherwise BUS. With BUS, cyc/stb/we/adr/dat/sel are driven from that same edge.
- DELAY:
  - cmd_ready=0.
  - After PRE_OP_DELAY cycles, drive the bus signals and enter BUS.
  - cyc_o therefore rises PRE_OP_DELAY edges after the accept edge.
- BUS:
  - cyc_o=stb_o=1. we_o/adr_o/sel_o/dat_o hold the latched values; dat_o=0 for reads.
  - Terminations are sampled each edge, priority ack > err > rty.
  - ack: deassert cyc/stb/we/sel, capture dat_i into rsp_rdata if read, status 00, go to IDLE.
  - err: deassert, status 01, go to IDLE; rsp_rdata unchanged.
  - rty with retries<MAX_RETRY: deassert, retries+1, go to GAP.
  - rty with retries==MAX_RETRY: deassert, status 10, go to IDLE.
  - Timeout: TIMEOUT>0 and cycle count in BUS reaches TIMEOUT with no termination. Deassert, status 11, go to IDLE. The timer resets on each BUS entry.
- GAP:
  - cyc_o=0 for RETRY_GAP cycles, then reissue with the same latched command and enter BUS. PRE_OP_DELAY is not reapplied.
- Response timing:
  - rsp_valid is high exactly the cycle after a terminating edge. rsp_status and rsp_retries are valid then and held until the next response.
  - cmd_ready returns high in that same cycle, so back-to-back commands are allowed.
- Commands presented while cmd_ready=0 are ignored; the requester must hold cmd_valid.
- Terminations in IDLE/DELAY/GAP (cyc low) are ignored.
- Counters: the retry counter is 8 bits and saturates at MAX_RETRY. The timer is wide enough for TIMEOUT; the last boundary never wraps.
- Sizing: MAX_RETRY ≤ 255.

Test Plan:
- Write with PRE_OP_DELAY=1: accept adr=0x3, wdata=0xA5, sel=0xF.
  - cyc_o rises 1 edge after accept with we_o=1, dat_o=0xA5.
  - Slave acks on the 3rd BUS cycle → rsp_valid 1 cycle, status 00, retries 0, cmd_ready high the same cycle.
- Read adr=0x4, slave acks with dat_i=0x5C → rsp_rdata=0x5C, we_o=0, dat_o=0.
  - A following err read leaves rsp_rdata=0x5C with status 01.
- rty twice then ack (MAX_RETRY=3, RETRY_GAP=4) → cyc_o low exactly 4 cycles between attempts, status 00, retries 2.
- rty on every attempt (MAX_RETRY=3) → 4 bus attempts, status 10, retries 3.
- No termination with TIMEOUT=16 → cyc_o high exactly 16 cycles, status 11.
  - ack+err+rty asserted together on one edge → status 00.
- Reset mid-BUS → cyc_o/stb_o low immediately (asynchronously), no rsp_valid.
  - After release: cmd_ready=1, and a new command completes normally.
- PRE_OP_DELAY=0 with back-to-back cmd_valid → cyc_o high the cycle after the accept edge; two acks yield two rsp_valid pulses with one idle cycle between bus cycles.

Source files
------------

// File: rtl/wb_host_ctrl.sv
// ============================================================================
// wb_host_ctrl : single-transaction Wishbone host with retry and timeout
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_host_ctrl #(
    parameter int DW           = 32,
    parameter int AW           = 32,
    parameter int PRE_OP_DELAY = 1,
    parameter int TIMEOUT      = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int RETRY_GAP    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic [1:0]      rsp_status,
    output logic [7:0]      rsp_retries,
    output logic            busy,
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    input  logic [DW-1:0]   dat_i,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [DW/8-1:0] sel_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            rty_i
);

    localparam int SW       = DW / 8;
    localparam int CNT_MAX0 = (PRE_OP_DELAY > TIMEOUT) ? PRE_OP_DELAY : TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > RETRY_GAP) ? CNT_MAX0 : RETRY_GAP;
    localparam int CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CW-1:0] C_DLY_LAST = CW'((PRE_OP_DELAY > 0) ? PRE_OP_DELAY - 1 : 0);
    localparam logic [CW-1:0] C_GAP_LAST = CW'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);
    localparam logic [CW-1:0] C_TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [7:0]    C_MAX_RETRY = 8'(MAX_RETRY);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_BUS   = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_retry;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_sel;

    logic w_accept, w_ack, w_err, w_rty, w_rty_more, w_rty_final, w_tmo, w_done;

    assign w_accept    = (r_state == S_IDLE) && cmd_valid && cmd_ready;
    assign w_ack       = (r_state == S_BUS) && ack_i;
    assign w_err       = (r_state == S_BUS) && !ack_i && err_i;
    assign w_rty       = (r_state == S_BUS) && !ack_i && !err_i && rty_i;
    assign w_rty_more  = w_rty && (r_retry != C_MAX_RETRY);
    assign w_rty_final = w_rty && (r_retry == C_MAX_RETRY);
    assign w_tmo       = (r_state == S_BUS) && (TIMEOUT > 0) && !ack_i && !err_i && !rty_i
                         && (r_cnt == C_TMO_LAST);
    assign w_done      = w_ack || w_err || w_rty_final || w_tmo;

    // State register, shared phase counter, retry count and latched command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_retry <= '0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || (r_state == S_IDLE))
                r_cnt <= '0;
            else if ((r_state != S_BUS) || (TIMEOUT > 0))
                r_cnt <= r_cnt + 1'b1;
            if (w_accept) begin
                r_retry <= '0;
                r_we    <= cmd_we;
                r_adr   <= cmd_adr;
                r_wdata <= cmd_wdata;
                r_sel   <= cmd_sel;
            end else if (w_rty_more) begin
                r_retry <= r_retry + 8'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (PRE_OP_DELAY > 0) ? S_DELAY : S_BUS;
            S_DELAY: if (r_cnt == C_DLY_LAST) w_next = S_BUS;
            S_BUS:   if (w_rty_more) w_next = S_GAP;
                     else if (w_done) w_next = S_IDLE;
            S_GAP:   if (r_cnt == C_GAP_LAST) w_next = S_BUS;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the accept edge bypasses the latch
    logic          w_cmd_we, w_bus;
    logic [AW-1:0] w_cmd_adr, w_adr_n;
    logic [DW-1:0] w_cmd_wdata, w_dat_n, w_rdata_n;
    logic [SW-1:0] w_cmd_sel, w_sel_n;
    logic [1:0]    w_status_n;
    logic [7:0]    w_retries_n;

    always_comb begin
        w_cmd_we    = w_accept ? cmd_we    : r_we;
        w_cmd_adr   = w_accept ? cmd_adr   : r_adr;
        w_cmd_wdata = w_accept ? cmd_wdata : r_wdata;
        w_cmd_sel   = w_accept ? cmd_sel   : r_sel;
        w_bus       = (w_next == S_BUS);
        w_sel_n     = w_bus ? w_cmd_sel : '0;
        w_adr_n     = w_bus ? w_cmd_adr : adr_o;
        w_dat_n     = w_bus ? (w_cmd_we ? w_cmd_wdata : '0) : dat_o;
        w_rdata_n   = rsp_rdata;
        w_status_n  = rsp_status;
        w_retries_n = w_done ? r_retry : rsp_retries;
        if (w_ack) begin
            w_status_n = 2'b00;
            if (!r_we) w_rdata_n = dat_i;
        end else if (w_err) begin
            w_status_n = 2'b01;
        end else if (w_rty_final) begin
            w_status_n = 2'b10;
        end else if (w_tmo) begin
            w_status_n = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_status  <= 2'b00;
            rsp_retries <= '0;
            busy        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            sel_o       <= '0;
        end else begin
            cmd_ready   <= (w_next == S_IDLE);
            rsp_valid   <= w_done;
            rsp_rdata   <= w_rdata_n;
            rsp_status  <= w_status_n;
            rsp_retries <= w_retries_n;
            busy        <= (w_next != S_IDLE);
            adr_o       <= w_adr_n;
            dat_o       <= w_dat_n;
            cyc_o       <= w_bus;
            stb_o       <= w_bus;
            we_o        <= w_bus && w_cmd_we;
            sel_o       <= w_sel_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_host_ctrl.sv
// ============================================================================
// tb_wb_host_ctrl : directed self-checking bench for wb_host_ctrl
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_host_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: PRE_OP_DELAY=1, TIMEOUT=16, MAX_RETRY=3, RETRY_GAP=4
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [7:0]  rsp_retries;
    logic        busy;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic        ack_i, err_i, rty_i;

    // DUT B: PRE_OP_DELAY=0 for back-to-back timing
    logic        b_cmd_valid, b_cmd_ready, b_cmd_we;
    logic [31:0] b_cmd_adr, b_cmd_wdata;
    logic [3:0]  b_cmd_sel;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_rdata;
    logic [1:0]  b_rsp_status;
    logic [7:0]  b_rsp_retries;
    logic        b_busy;
    logic [31:0] b_adr_o, b_dat_o, b_dat_i;
    logic        b_cyc_o, b_stb_o, b_we_o;
    logic [3:0]  b_sel_o;
    logic        b_ack_i, b_err_i, b_rty_i;

    wb_host_ctrl #(.DW(32), .AW(32), .PRE_OP_DELAY(1), .TIMEOUT(16), .MAX_RETRY(3), .RETRY_GAP(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_status(rsp_status), .rsp_retries(rsp_retries), .busy(busy),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .sel_o(sel_o), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    wb_host_ctrl #(.DW(32), .AW(32), .PRE_OP_DELAY(0), .TIMEOUT(16), .MAX_RETRY(3), .RETRY_GAP(4)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_we(b_cmd_we),
        .cmd_adr(b_cmd_adr), .cmd_wdata(b_cmd_wdata), .cmd_sel(b_cmd_sel), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_status(b_rsp_status), .rsp_retries(b_rsp_retries), .busy(b_busy),
        .adr_o(b_adr_o), .dat_o(b_dat_o), .dat_i(b_dat_i), .cyc_o(b_cyc_o), .stb_o(b_stb_o), .we_o(b_we_o),
        .sel_o(b_sel_o), .ack_i(b_ack_i), .err_i(b_err_i), .rty_i(b_rty_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
        int n;
        n = 0;
        cmd_we = we; cmd_adr = adr; cmd_wdata = wd; cmd_sel = sel;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check_val("issue_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cyc(output int n, input int budget);
        n = 0;
        while (!cyc_o && n < budget) begin
            step();
            n++;
        end
        if (!cyc_o) check_val("cyc_wait_timeout", cyc_o, 1);
    endtask

    // Hold the slave quiet until the given BUS cycle, then terminate on it
    task automatic term(input int bus_cycle, input logic [2:0] aer);
        for (int i = 1; i < bus_cycle; i++) step();
        {ack_i, err_i, rty_i} = aer;
        step();
        {ack_i, err_i, rty_i} = 3'b000;
    endtask

    task automatic rsp_check(input string tag, input logic [1:0] status, input logic [7:0] retries);
        check_val({tag, "_valid"}, rsp_valid, 1);
        check_val({tag, "_status"}, rsp_status, status);
        check_val({tag, "_retries"}, rsp_retries, retries);
        check_val({tag, "_ready"}, cmd_ready, 1);
        step();
        check_val({tag, "_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int attempts;
        int seen;
        cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_wdata = 0; cmd_sel = 0;
        dat_i = 0; ack_i = 0; err_i = 0; rty_i = 0;
        b_cmd_valid = 0; b_cmd_we = 0; b_cmd_adr = 0; b_cmd_wdata = 0; b_cmd_sel = 0;
        b_dat_i = 0; b_ack_i = 0; b_err_i = 0; b_rty_i = 0;

        // Reset values
        repeat (3) step();
        check_val("rst_ready", cmd_ready, 0);
        check_val("rst_cyc", cyc_o, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_busy", busy, 0);
        rst = 1'b0;
        step();
        check_val("post_rst_ready", cmd_ready, 1);
        check_val("post_rst_ready_b", b_cmd_ready, 1);

        // Write, acked on 3rd BUS cycle
        issue(1'b1, 32'h3, 32'hA5, 4'hF);
        check_val("wr_delay_ready", cmd_ready, 0);
        check_val("wr_delay_busy", busy, 1);
        check_val("wr_delay_cyc", cyc_o, 0);
        wait_cyc(n, 10);
        check_val("wr_cyc_rise", n, 1);
        check_val("wr_we", we_o, 1);
        check_val("wr_stb", stb_o, 1);
        check_val("wr_dat", dat_o, 32'hA5);
        check_val("wr_adr", adr_o, 32'h3);
        check_val("wr_sel", sel_o, 4'hF);
        term(3, 3'b100);
        check_val("wr_cyc_drop", cyc_o, 0);
        rsp_check("wr", 2'b00, 8'd0);

        // Read acked with data, then a read terminated by err
        dat_i = 32'h5C;
        issue(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF);
        wait_cyc(n, 10);
        check_val("rd_we", we_o, 0);
        check_val("rd_dat_o", dat_o, 0);
        check_val("rd_adr", adr_o, 32'h4);
        term(2, 3'b100);
        check_val("rd_rdata", rsp_rdata, 32'h5C);
        rsp_check("rd", 2'b00, 8'd0);
        dat_i = 32'hDEAD_BEEF;
        issue(1'b0, 32'h8, 32'h0, 4'hF);
        wait_cyc(n, 10);
        term(1, 3'b010);
        check_val("err_rdata", rsp_rdata, 32'h5C);
        rsp_check("err", 2'b01, 8'd0);

        // Two retries then ack
        issue(1'b1, 32'h10, 32'h1234, 4'h3);
        wait_cyc(n, 10);
        term(1, 3'b001);
        check_val("rty1_no_rsp", rsp_valid, 0);
        check_val("rty1_cyc_low", cyc_o, 0);
        wait_cyc(n, 20);
        check_val("rty1_gap", n, 4);
        term(1, 3'b001);
        wait_cyc(n, 20);
        check_val("rty2_gap", n, 4);
        check_val("rty2_adr", adr_o, 32'h10);
        check_val("rty2_dat", dat_o, 32'h1234);
        check_val("rty2_sel", sel_o, 4'h3);
        term(1, 3'b100);
        rsp_check("rty_ack", 2'b00, 8'd2);

        // Retry on every attempt: initial + 3 retries
        issue(1'b0, 32'h20, 32'h0, 4'hF);
        attempts = 0;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(n, 20);
            if (cyc_o) attempts++;
            term(1, 3'b001);
        end
        check_val("rtyx_attempts", attempts, 4);
        rsp_check("rtyx", 2'b10, 8'd3);
        seen = 0;
        repeat (6) begin
            step();
            if (cyc_o) seen++;
        end
        check_val("rtyx_no_reissue", seen, 0);

        // Timeout after 16 cycles of cyc high
        issue(1'b1, 32'h30, 32'h77, 4'hF);
        wait_cyc(n, 10);
        n = 1;
        while (cyc_o && n < 100) begin
            step();
            if (cyc_o) n++;
        end
        check_val("tmo_len", n, 16);
        rsp_check("tmo", 2'b11, 8'd0);

        // ack, err and rty together: ack wins
        issue(1'b1, 32'h40, 32'h88, 4'hF);
        wait_cyc(n, 10);
        term(1, 3'b111);
        rsp_check("prio", 2'b00, 8'd0);

        // Asynchronous reset mid-BUS
        issue(1'b1, 32'h50, 32'h99, 4'hF);
        wait_cyc(n, 10);
        step();
        #2 rst = 1'b1;
        #1;
        check_val("arst_cyc", cyc_o, 0);
        check_val("arst_stb", stb_o, 0);
        seen = 0;
        repeat (3) begin
            step();
            if (rsp_valid) seen++;
        end
        check_val("arst_no_rsp", seen, 0);
        check_val("arst_ready", cmd_ready, 0);
        rst = 1'b0;
        step();
        check_val("arst_rel_ready", cmd_ready, 1);
        issue(1'b1, 32'h60, 32'hAB, 4'h1);
        wait_cyc(n, 10);
        check_val("arst_new_dat", dat_o, 32'hAB);
        term(2, 3'b100);
        rsp_check("arst_new", 2'b00, 8'd0);

        // Back-to-back on the zero-delay instance
        b_cmd_we = 1'b1; b_cmd_adr = 32'h70; b_cmd_wdata = 32'h11; b_cmd_sel = 4'hF;
        check_val("b2b_ready0", b_cmd_ready, 1);
        b_cmd_valid = 1'b1;
        step();
        check_val("b2b_cyc1", b_cyc_o, 1);
        check_val("b2b_ready_busy", b_cmd_ready, 0);
        b_ack_i = 1'b1;
        step();
        b_ack_i = 1'b0;
        check_val("b2b_rsp1", b_rsp_valid, 1);
        check_val("b2b_idle_cyc", b_cyc_o, 0);
        check_val("b2b_ready1", b_cmd_ready, 1);
        b_cmd_wdata = 32'h22;
        step();
        check_val("b2b_cyc2", b_cyc_o, 1);
        check_val("b2b_dat2", b_dat_o, 32'h22);
        check_val("b2b_gap_rsp", b_rsp_valid, 0);
        b_cmd_valid = 1'b0;
        b_ack_i = 1'b1;
        step();
        b_ack_i = 1'b0;
        check_val("b2b_rsp2", b_rsp_valid, 1);
        check_val("b2b_status2", b_rsp_status, 2'b00);
        step();
        check_val("b2b_pulse2", b_rsp_valid, 0);
        check_val("b2b_cyc_end", b_cyc_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
